// File: rtl/multiplicador_seq8x8_pkg.sv
// Shared ALU constants: datapath width, shift-add iteration count and the
// FSM state encoding used by the sequential multiplier.
package multiplicador_seq8x8_pkg;

  localparam int DATA_W = 8;
  localparam int ITER_N = 8;
  localparam int CNT_W  = $clog2(ITER_N + 1);
  localparam int PROD_W = 2 * DATA_W;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage : multiplicador_seq8x8_pkg

// File: rtl/mux2_8.sv
// 8-bit 2:1 multiplexer: y = sel ? d1 : d0.
module mux2_8
  import multiplicador_seq8x8_pkg::*;
(
  input  logic              sel,
  input  logic [DATA_W-1:0] d0,
  input  logic [DATA_W-1:0] d1,
  output logic [DATA_W-1:0] y
);

  assign y = sel ? d1 : d0;

endmodule : mux2_8

// File: rtl/somador8.sv
// 8-bit ripple-carry adder: a + b -> 9-bit sum, the MSB being the carry out.
module somador8
  import multiplicador_seq8x8_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W:0]   sum
);

  logic [DATA_W:0] carry;

  assign carry[0] = 1'b0;

  // One full adder per bit, carry rippling from LSB to MSB.
  for (genvar i = 0; i < DATA_W; i++) begin : g_fa
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign sum[DATA_W] = carry[DATA_W];

endmodule : somador8

// File: rtl/multiplicador_seq8x8.sv
// Sequential 8x8 unsigned shift-add multiplier. A start in IDLE captures the
// operands; eight CALC cycles add-and-shift {carry, acc, multiplier}; DONE
// pulses done for one cycle with the registered product and overflow flag.
module multiplicador_seq8x8
  import multiplicador_seq8x8_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic [PROD_W-1:0] P,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  state_t              state;
  state_t              state_next;
  logic [DATA_W-1:0]   mcand;
  logic [DATA_W-1:0]   mplier;
  logic [PROD_W-1:0]   acc;
  logic [CNT_W-1:0]    cnt;

  logic [DATA_W:0]     sum;
  logic [DATA_W-1:0]   high_sel;
  logic                carry;
  logic [PROD_W-1:0]   acc_shift;
  logic [DATA_W-1:0]   mplier_shift;
  logic                last_iter;

  somador8 u_somador8 (
    .a   (mcand),
    .b   (acc[PROD_W-1:DATA_W]),
    .sum (sum)
  );

  // Keep the upper accumulator half unless the current multiplier bit is set.
  mux2_8 u_mux2_8 (
    .sel (mplier[0]),
    .d0  (acc[PROD_W-1:DATA_W]),
    .d1  (sum[DATA_W-1:0]),
    .y   (high_sel)
  );

  // The carry only enters the shift when the add actually happened.
  assign carry        = mplier[0] & sum[DATA_W];
  assign acc_shift    = {carry, high_sel, acc[DATA_W-1:1]};
  assign mplier_shift = {acc[0], mplier[DATA_W-1:1]};
  assign last_iter    = (cnt == CNT_W'(1));

  // State register; reset wins over any pending start.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_next = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (last_iter) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, add-and-shift iterations and result register.
  always_ff @(posedge clk) begin
    // NOTE: the datapath registers are reset too: an abort must leave P at
    // zero and no stale operands or partial sums behind.
    if (rst) begin
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
      P        <= '0;
      overflow <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            mcand  <= A;
            mplier <= B;
            acc    <= '0;
            cnt    <= CNT_W'(ITER_N);
          end
        end
        CALC: begin
          acc    <= acc_shift;
          mplier <= mplier_shift;
          cnt    <= cnt - CNT_W'(1);
          // P only ever sees the finished product, never a partial sum.
          if (last_iter) begin
            P        <= acc_shift;
            overflow <= |acc_shift[PROD_W-1:DATA_W];
          end
        end
        default: ;
      endcase
    end
  end

endmodule : multiplicador_seq8x8
